// File: rtl/alu_pkg.sv
// Shared opcode encoding and arbiter state encoding for the two-port ALU arbiter.
package alu_pkg;

  localparam int unsigned DataW = 8;
  localparam int unsigned CtrlW = 4;

  localparam logic [CtrlW-1:0] OpAdd = 4'h0;
  localparam logic [CtrlW-1:0] OpSub = 4'h1;
  localparam logic [CtrlW-1:0] OpAnd = 4'h2;
  localparam logic [CtrlW-1:0] OpOr  = 4'h3;
  localparam logic [CtrlW-1:0] OpNot = 4'h4;
  localparam logic [CtrlW-1:0] OpXor = 4'h5;
  localparam logic [CtrlW-1:0] OpNor = 4'h6;
  localparam logic [CtrlW-1:0] OpShl = 4'h7;
  localparam logic [CtrlW-1:0] OpShr = 4'h8;
  localparam logic [CtrlW-1:0] OpAsr = 4'h9;
  localparam logic [CtrlW-1:0] OpRol = 4'hA;
  localparam logic [CtrlW-1:0] OpRor = 4'hB;
  localparam logic [CtrlW-1:0] OpEq  = 4'hC;
  // 4'hD..4'hF are reserved and flag an error.
  localparam logic [CtrlW-1:0] OpRsvdLo = 4'hD;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 8-bit ALU with carry and reserved-opcode error flag.
module alu_core
  import alu_pkg::*;
(
  input  logic [CtrlW-1:0] ctrl_i,
  input  logic [DataW-1:0] x_i,
  input  logic [DataW-1:0] y_i,
  output logic [DataW-1:0] out_o,
  output logic             carry_o,
  output logic             err_o
);

  logic [DataW:0] sum;

  always_comb begin
    sum     = '0;
    out_o   = '0;
    carry_o = 1'b0;
    err_o   = 1'b0;
    case (ctrl_i)
      OpAdd: begin
        // Operands are sign-extended to 9 bits, so carry is the 9th result bit.
        sum     = {x_i[DataW-1], x_i} + {y_i[DataW-1], y_i};
        out_o   = sum[DataW-1:0];
        carry_o = sum[DataW];
      end
      OpSub: begin
        sum     = {x_i[DataW-1], x_i} - {y_i[DataW-1], y_i};
        out_o   = sum[DataW-1:0];
        carry_o = sum[DataW];
      end
      OpAnd: out_o = x_i & y_i;
      OpOr:  out_o = x_i | y_i;
      OpNot: out_o = ~x_i;
      OpXor: out_o = x_i ^ y_i;
      OpNor: out_o = ~(x_i | y_i);
      OpShl: out_o = y_i << x_i[2:0];
      OpShr: out_o = y_i >> x_i[2:0];
      OpAsr: out_o = {x_i[DataW-1], x_i[DataW-1:1]};
      OpRol: out_o = {x_i[DataW-2:0], x_i[DataW-1]};
      OpRor: out_o = {x_i[0], x_i[DataW-1:1]};
      OpEq:  out_o = (x_i == y_i) ? 8'h01 : 8'h00;
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a round-robin arbiter and a one-entry
// response register that supports back-to-back transfers.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [CtrlW-1:0] req0_ctrl,
  input  logic [DataW-1:0] req0_x,
  input  logic [DataW-1:0] req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [CtrlW-1:0] req1_ctrl,
  input  logic [DataW-1:0] req1_x,
  input  logic [DataW-1:0] req1_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [DataW-1:0] rsp_out,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [7:0]       gnt_cnt0,
  output logic [7:0]       gnt_cnt1
);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [DataW-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [7:0]       cnt0_q, cnt0_d;
  logic [7:0]       cnt1_q, cnt1_d;

  logic             win1, accept_ok, grant0, grant1, accept;
  logic [CtrlW-1:0] sel_ctrl;
  logic [DataW-1:0] sel_x, sel_y, alu_out;
  logic             alu_carry, alu_err;

  alu_core u_alu_core (
    .ctrl_i  (sel_ctrl),
    .x_i     (sel_x),
    .y_i     (sel_y),
    .out_o   (alu_out),
    .carry_o (alu_carry),
    .err_o   (alu_err)
  );

  always_comb begin
    // last_q == 1 means requester 1 was granted last, so requester 0 wins a tie.
    win1      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    accept_ok = (state_q == StEmpty) || rsp_ready;
    grant0    = rst_n && accept_ok && req0_valid && !win1;
    grant1    = rst_n && accept_ok && req1_valid && win1;
    accept    = grant0 || grant1;

    sel_ctrl = win1 ? req1_ctrl : req0_ctrl;
    sel_x    = win1 ? req1_x    : req0_x;
    sel_y    = win1 ? req1_y    : req0_y;

    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    out_d   = out_q;
    carry_d = carry_q;
    err_d   = err_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;

    case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (rsp_ready && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase

    if (accept) begin
      last_d  = win1;
      id_d    = win1;
      out_d   = alu_out;
      carry_d = alu_carry;
      err_d   = alu_err;
    end
    if (grant0 && (cnt0_q != 8'hFF)) cnt0_d = cnt0_q + 8'd1;
    if (grant1 && (cnt1_q != 8'hFF)) cnt1_d = cnt1_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state_q == StFull);
  assign rsp_id     = id_q;
  assign rsp_out    = out_q;
  assign rsp_carry  = carry_q;
  assign rsp_err    = err_q;
  assign gnt_cnt0   = cnt0_q;
  assign gnt_cnt1   = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a cycle model predicts grants and results.
module tb_alu_arbiter;

  logic       clk, rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_ctrl, req1_ctrl;
  logic [7:0] req0_x, req0_y, req1_x, req1_y;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
  logic [7:0] rsp_out, gnt_cnt0, gnt_cnt1;

  typedef struct packed {
    logic       id;
    logic       err;
    logic       carry;
    logic [7:0] out;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   m_full;
  bit   m_last;
  int   m_cnt0, m_cnt1;

  alu_arbiter u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_ctrl  (req0_ctrl),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_ctrl  (req1_ctrl),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_out    (rsp_out),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err),
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Returns {err, carry, out}.
  function automatic logic [9:0] model_alu(input logic [3:0] c, input logic [7:0] x,
                                           input logic [7:0] y);
    logic [8:0] t;
    case (c)
      4'd0: begin t = {x[7], x} + {y[7], y}; return {1'b0, t}; end
      4'd1: begin t = {x[7], x} - {y[7], y}; return {1'b0, t}; end
      4'd2:  return {2'b00, x & y};
      4'd3:  return {2'b00, x | y};
      4'd4:  return {2'b00, ~x};
      4'd5:  return {2'b00, x ^ y};
      4'd6:  return {2'b00, ~(x | y)};
      4'd7:  return {2'b00, y << x[2:0]};
      4'd8:  return {2'b00, y >> x[2:0]};
      4'd9:  return {2'b00, x[7], x[7:1]};
      4'd10: return {2'b00, x[6:0], x[7]};
      4'd11: return {2'b00, x[0], x[7:1]};
      4'd12: return {2'b00, 7'd0, (x == y)};
      default: return {1'b1, 1'b0, 8'h00};
    endcase
  endfunction

  function automatic exp_t observed();
    return {rsp_id, rsp_err, rsp_carry, rsp_out};
  endfunction

  // Checks the current cycle against the model, then advances one clock.
  task automatic cycle();
    logic       w1, acc_ok, e_r0, e_r1;
    logic [9:0] r;
    exp_t       e;
    #1;
    acc_ok = !m_full || rsp_ready;
    w1     = (req0_valid && req1_valid) ? !m_last : req1_valid;
    e_r0   = acc_ok && req0_valid && !w1;
    e_r1   = acc_ok && req1_valid && w1;
    check_eq("req0_ready", req0_ready, e_r0);
    check_eq("req1_ready", req1_ready, e_r1);
    check_eq("rsp_valid", rsp_valid, m_full);
    check_eq("gnt_cnt0", gnt_cnt0, m_cnt0);
    check_eq("gnt_cnt1", gnt_cnt1, m_cnt1);
    if (m_full && sb_q.size() > 0) begin
      check_eq("rsp", observed(), sb_q[0]);
      if (rsp_ready) void'(sb_q.pop_front());
    end
    if (e_r0 || e_r1) begin
      r = e_r1 ? model_alu(req1_ctrl, req1_x, req1_y) : model_alu(req0_ctrl, req0_x, req0_y);
      e = {e_r1, r};
      sb_q.push_back(e);
      m_last = e_r1;
      if (e_r1) begin if (m_cnt1 < 255) m_cnt1++; end
      else begin if (m_cnt0 < 255) m_cnt0++; end
      m_full = 1'b1;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_req0_ready", req0_ready, 1'b0);
    check_eq("rst_req1_ready", req1_ready, 1'b0);
    check_eq("rst_cnt0", gnt_cnt0, 8'd0);
    check_eq("rst_cnt1", gnt_cnt1, 8'd0);
    check_eq("rst_rsp", observed(), 11'd0);
    m_full = 1'b0;
    m_last = 1'b1;
    m_cnt0 = 0;
    m_cnt1 = 0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic rand_ops();
    req0_ctrl = 4'($urandom_range(15, 0));
    req1_ctrl = 4'($urandom_range(15, 0));
    req0_x = 8'($urandom);
    req0_y = 8'($urandom);
    req1_x = 8'($urandom);
    req1_y = 8'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_ctrl = '0; req0_x = '0; req0_y = '0;
    req1_ctrl = '0; req1_x = '0; req1_y = '0;
    do_reset();

    // Contended add/sub: req0 first, then req1.
    req0_ctrl = 4'h0; req0_x = 8'h7F; req0_y = 8'h01; req0_valid = 1'b1;
    req1_ctrl = 4'h1; req1_x = 8'h00; req1_y = 8'h01; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    cycle();
    req0_valid = 1'b0;
    cycle();
    req1_valid = 1'b0;
    cycle();

    // Backpressure: result held, no grants.
    req0_ctrl = 4'h0; req0_x = 8'h80; req0_y = 8'h80; req0_valid = 1'b1;
    rsp_ready = 1'b0;
    cycle();
    req1_ctrl = 4'h2; req1_valid = 1'b1;
    repeat (3) cycle();
    check_eq("held_out", {rsp_carry, rsp_out}, 9'h100);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    cycle();

    // Continuous contention alternates grants.
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (8) begin
      rand_ops();
      cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cycle();
    check_eq("alt_cnt0", gnt_cnt0, 8'd4);
    check_eq("alt_cnt1", gnt_cnt1, 8'd4);

    // Reserved opcode and shift-left.
    req1_ctrl = 4'hE; req1_x = 8'h55; req1_y = 8'h33; req1_valid = 1'b1;
    cycle();
    req1_valid = 1'b0;
    check_eq("rsvd_err", {rsp_err, rsp_carry, rsp_out}, 10'h200);
    req0_ctrl = 4'h7; req0_x = 8'h03; req0_y = 8'h11; req0_valid = 1'b1;
    cycle();
    req0_valid = 1'b0;
    check_eq("shl_out", {rsp_err, rsp_out}, 9'h088);
    cycle();

    // Every opcode once from each side.
    for (int op = 0; op < 16; op++) begin
      rand_ops();
      req0_ctrl = 4'(op);
      req1_ctrl = 4'(15 - op);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      cycle();
      cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cycle();

    // Random traffic, including valids dropped before grant.
    repeat (200) begin
      rand_ops();
      req0_valid = 1'($urandom_range(1, 0));
      req1_valid = 1'($urandom_range(1, 0));
      rsp_ready = 1'($urandom_range(1, 0));
      cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    cycle();

    // Counter saturation.
    req0_valid = 1'b1;
    repeat (300) begin
      rand_ops();
      cycle();
    end
    req0_valid = 1'b0;
    cycle();
    check_eq("sat_cnt0", gnt_cnt0, 8'd255);

    // Reset while a result is held.
    req0_ctrl = 4'h0; req0_x = 8'h12; req0_y = 8'h34; req0_valid = 1'b1;
    rsp_ready = 1'b0;
    cycle();
    do_reset();
    rsp_ready = 1'b1;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; data width fixed at 8, opcode width fixed at 4.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_ctrl / req0_x / req0_y  input  4/8/8  requester 0 opcode and operands.
REQ-007 req1_valid, req1_ready, req1_ctrl, req1_x, req1_y  same directions/widths/meanings for requester 1.
REQ-008 rsp_valid  output  1  response register holds a result.
REQ-009 rsp_ready  input  1  consumer takes the response this cycle.
REQ-010 rsp_id  output  1  index of the requester that issued the result.
REQ-011 rsp_out  output  8  ALU result.
REQ-012 rsp_carry  output  1  ALU carry; 0 for opcodes other than 0000/0001.
REQ-013 rsp_err  output  1  opcode was reserved (1101-1111).
REQ-014 gnt_cnt0 / gnt_cnt1  output  8/8  saturating count of accepted operations per requester.

Function
REQ-015 Block SHALL share one 8-bit ALU instance between two requesters with valid/ready handshakes.
REQ-016 Transfer on a request port SHALL occur when reqN_valid and reqN_ready are both 1 on a rising edge; at most one requester SHALL be granted per cycle.
REQ-017 Accept condition SHALL be: response register empty, or rsp_valid and rsp_ready both 1 in the same cycle.
REQ-018 reqN_ready SHALL be 1 only when the accept condition holds and requester N wins arbitration; it SHALL NOT depend on rsp_out, rsp_id or reqN_ctrl/x/y.
REQ-019 Arbitration SHALL be round-robin: a single valid requester wins; if both are valid, the requester not granted last wins; last-grant pointer SHALL update only on an accepted transfer.
REQ-020 FSM states SHALL be EMPTY (rsp_valid=0) and FULL (rsp_valid=1); EMPTY->FULL on accept; FULL->EMPTY on rsp_ready without accept; FULL->FULL on rsp_ready with accept (back-to-back, one result per cycle).
REQ-021 Latency SHALL be one cycle: operands accepted at edge N produce rsp_valid=1 with the result after edge N.
REQ-022 While FULL and rsp_ready=0, rsp_out, rsp_carry, rsp_id and rsp_err SHALL hold stable and no requester SHALL be granted.
REQ-023 Add (0000) SHALL compute {carry,out} = {x[7],x} + {y[7],y} mod 2^9; subtract (0001) SHALL compute {x[7],x} - {y[7],y} mod 2^9.
REQ-024 Opcodes 0010-1100 SHALL follow the team ALU encoding (and, or, not x, xor, nor, y<<x[2:0], y>>x[2:0], arithmetic >>1 of x, rotate-left x, rotate-right x, equality -> 1/0), carry=0.
REQ-025 Opcodes 1101-1111 SHALL produce rsp_out=0, rsp_carry=0, rsp_err=1; all other opcodes rsp_err=0.
REQ-026 gnt_cntN SHALL increment by 1 per accepted transfer from requester N and saturate at 255.
REQ-027 A requester dropping reqN_valid before being granted SHALL have no effect on state or counters.

Reset
REQ-028 rst_n low SHALL immediately force FSM=EMPTY, rsp_valid=0, rsp_out=0, rsp_carry=0, rsp_id=0, rsp_err=0, gnt_cnt0=gnt_cnt1=0, last-grant pointer=1 (requester 0 wins the first contended cycle).
REQ-029 Reset asserted mid-operation SHALL discard any held result without it being presented; reqN_ready SHALL be 0 while rst_n is low.
REQ-030 First grant SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Opcode constants (ADD=0000 ... EQ=1100, reserved range) SHALL live in shared package alu_pkg, along with the EMPTY/FULL state encoding.
REQ-032 The datapath SHALL be one instantiated sub-module, alu_core (combinational 8-bit ALU with carry), fed by the granted requester's mux output.

Verification
REQ-033 Both valid, add 0x7F+0x01 on req0, sub 0x00-0x01 on req1, rsp_ready=1 -> cycle 1 rsp_id=0 out=0x80 carry=0; cycle 2 rsp_id=1 out=0xFF carry=1.
REQ-034 req0 add 0x80+0x80, rsp_ready=0 for 3 cycles -> rsp_out=0x00 carry=1 held stable, req0_ready and req1_ready stay 0, then one transfer on rsp_ready=1.
REQ-035 Both valid continuously for 8 cycles, rsp_ready=1 -> grants alternate 0,1,0,1...; gnt_cnt0=gnt_cnt1=4.
REQ-036 req1 ctrl=1110, x=0x55 -> rsp_out=0x00 carry=0 err=1; req0 ctrl=0111 x=0x03 y=0x11 -> out=0x88 err=0.
REQ-037 300 accepted req0 transfers -> gnt_cnt0=255 and holds.
REQ-038 rst_n pulsed low while FULL -> rsp_valid=0 immediately, counters 0, no stale response after release.
